// File: rtl/bit_deserializer_if.sv
// Serial-in / parallel-out bus bundle for bit_deserializer.
// DESER_PARITY_EN adds the parity_err signal to the bundle.
interface bit_deserializer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             bit_in;
    logic             bit_valid;
    logic             word_ready;
    logic             clr_ovf;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             overflow;
    logic [CNT_W-1:0] bit_count;
`ifdef DESER_PARITY_EN
    logic             parity_err;

    modport master (
        output bit_in, bit_valid, word_ready, clr_ovf,
        input  word_out, word_valid, overflow, bit_count, parity_err
    );
    modport slave (
        input  bit_in, bit_valid, word_ready, clr_ovf,
        output word_out, word_valid, overflow, bit_count, parity_err
    );
`else
    modport master (
        output bit_in, bit_valid, word_ready, clr_ovf,
        input  word_out, word_valid, overflow, bit_count
    );
    modport slave (
        input  bit_in, bit_valid, word_ready, clr_ovf,
        output word_out, word_valid, overflow, bit_count
    );
`endif
endinterface

// File: rtl/bit_deserializer.sv
// Serial-to-parallel deserializer with a one-word output register and sticky overflow.
// Optional macro DESER_PARITY_EN appends an even-parity bit to each frame and adds parity_err.
module bit_deserializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    bit_deserializer_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef DESER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME - 2);

    typedef enum logic {
        COLLECT  = 1'b0,
        COMPLETE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             perr_q, perr_d;

    logic [WIDTH-1:0] shifted_c;
    logic [WIDTH-1:0] new_word_c;
    logic             new_perr_c;
    logic             complete_c;
    logic             consume_c;

    assign shifted_c = MSB_FIRST ? {sr_q[WIDTH-2:0], bus.bit_in}
                                 : {bus.bit_in, sr_q[WIDTH-1:1]};

    // With parity the final frame bit is the parity bit, so the data is already fully shifted in.
`ifdef DESER_PARITY_EN
    assign new_word_c = sr_q;
    assign new_perr_c = (^sr_q) ^ bus.bit_in;
`else
    assign new_word_c = shifted_c;
    assign new_perr_c = 1'b0;
`endif

    assign complete_c = bus.bit_valid && (state_q == COMPLETE);
    assign consume_c  = valid_q && bus.word_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            sr_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        word_d  = word_q;
        valid_d = valid_q;
        ovf_d   = bus.clr_ovf ? 1'b0 : ovf_q;
        perr_d  = perr_q;

        if (bus.bit_valid) begin
            case (state_q)
                COLLECT: begin
                    sr_d    = shifted_c;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q == PRE_LAST) ? COMPLETE : COLLECT;
                end
                COMPLETE: begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = COLLECT;
                end
                default: state_d = COLLECT;
            endcase
        end

        // Output register: load when empty or being drained, otherwise drop and flag.
        if (complete_c) begin
            if (!valid_q || bus.word_ready) begin
                word_d  = new_word_c;
                perr_d  = new_perr_c;
                valid_d = 1'b1;
            end else begin
                ovf_d   = 1'b1;
            end
        end else if (consume_c) begin
            valid_d = 1'b0;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.overflow   = ovf_q;
    assign bus.bit_count  = cnt_q;
`ifdef DESER_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q ^ new_perr_c;
`endif
endmodule

// File: tb/tb_bit_deserializer.sv
// Directed self-checking bench for bit_deserializer (MSB-first and LSB-first instances).
// Honors DESER_PARITY_EN by sending a ninth parity bit per frame.
module tb_bit_deserializer;
`ifdef DESER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bit_deserializer_if #(.WIDTH(8)) if_m ();
    bit_deserializer_if #(.WIDTH(8)) if_l ();

    assign if_l.bit_in     = if_m.bit_in;
    assign if_l.bit_valid  = if_m.bit_valid;
    assign if_l.word_ready = if_m.word_ready;
    assign if_l.clr_ovf    = if_m.clr_ovf;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(if_m));
    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends frame bits first..last-1; index 8 is the parity bit (even parity, optionally corrupted).
    task automatic send_frame(input logic [7:0] w, input bit inject, input int first, input int last);
        for (int k = first; k < last; k++) begin
            if_m.bit_in    = (k < 8) ? w[7-k] : ((^w) ^ inject);
            if_m.bit_valid = 1'b1;
            tick();
            if_m.bit_valid = 1'b0;
        end
    endtask

    initial begin
        rst             = 1'b1;
        if_m.bit_in     = 1'b0;
        if_m.bit_valid  = 1'b0;
        if_m.word_ready = 1'b0;
        if_m.clr_ovf    = 1'b0;
        #2;
        check("rst_word_out",  32'(if_m.word_out),   32'h00);
        check("rst_valid",     32'(if_m.word_valid), 32'h0);
        check("rst_overflow",  32'(if_m.overflow),   32'h0);
        check("rst_bit_count", 32'(if_m.bit_count),  32'h0);
        check("rst_lsb_word",  32'(if_l.word_out),   32'h00);
        tick();
        rst = 1'b0;

        // Basic word, MSB-first and LSB-first
        if_m.word_ready = 1'b1;
        send_frame(8'hB2, 1'b0, 0, 7);
        check("b2_count7", 32'(if_m.bit_count),  32'd7);
        check("b2_valid7", 32'(if_m.word_valid), 32'h0);
        send_frame(8'hB2, 1'b0, 7, FRAME);
        check("b2_valid",  32'(if_m.word_valid), 32'h1);
        check("b2_word",   32'(if_m.word_out),   32'hB2);
        check("b2_count0", 32'(if_m.bit_count),  32'd0);
        check("lsb_word",  32'(if_l.word_out),   32'h4D);
        tick();
        check("b2_one_cycle", 32'(if_m.word_valid), 32'h0);
        check("b2_hold_word", 32'(if_m.word_out),   32'hB2);

        // Overflow with stalled consumer, gaps in bit_valid
        if_m.word_ready = 1'b0;
        send_frame(8'hB2, 1'b0, 0, FRAME);
        check("ovf_first_valid", 32'(if_m.word_valid), 32'h1);
        for (int k = 0; k < 4; k++) begin
            send_frame(8'hFF, 1'b0, k, k + 1);
            tick();
        end
        check("gap_count4", 32'(if_m.bit_count), 32'd4);
        send_frame(8'hFF, 1'b0, 4, FRAME);
        check("ovf_word_kept", 32'(if_m.word_out),   32'hB2);
        check("ovf_valid",     32'(if_m.word_valid), 32'h1);
        check("ovf_set",       32'(if_m.overflow),   32'h1);
        check("ovf_count0",    32'(if_m.bit_count),  32'd0);
        if_m.clr_ovf = 1'b1;
        tick();
        if_m.clr_ovf = 1'b0;
        check("ovf_cleared", 32'(if_m.overflow), 32'h0);
        send_frame(8'hFF, 1'b0, 0, FRAME - 1);
        if_m.clr_ovf = 1'b1;
        send_frame(8'hFF, 1'b0, FRAME - 1, FRAME);
        if_m.clr_ovf = 1'b0;
        check("ovf_set_wins",   32'(if_m.overflow), 32'h1);
        check("ovf_word_kept2", 32'(if_m.word_out), 32'hB2);
        if_m.clr_ovf = 1'b1;
        tick();
        if_m.clr_ovf    = 1'b0;
        if_m.word_ready = 1'b1;
        tick();
        check("ovf_drained", 32'(if_m.word_valid), 32'h0);
        check("ovf_clear2",  32'(if_m.overflow),   32'h0);

        // Back-to-back replacement without a bubble
        send_frame(8'h12, 1'b0, 0, FRAME);
        check("b2b_w1", 32'(if_m.word_out), 32'h12);
        if_m.word_ready = 1'b0;
        send_frame(8'h34, 1'b0, 0, FRAME - 1);
        check("b2b_stall_valid", 32'(if_m.word_valid), 32'h1);
        check("b2b_stall_word",  32'(if_m.word_out),   32'h12);
        if_m.word_ready = 1'b1;
        send_frame(8'h34, 1'b0, FRAME - 1, FRAME);
        check("b2b_valid",   32'(if_m.word_valid), 32'h1);
        check("b2b_w2",      32'(if_m.word_out),   32'h34);
        check("b2b_no_ovf",  32'(if_m.overflow),   32'h0);
        tick();
        check("b2b_drained", 32'(if_m.word_valid), 32'h0);

        // Reset mid-word discards the partial word
        send_frame(8'hFF, 1'b0, 0, 5);
        check("mid_count5", 32'(if_m.bit_count), 32'd5);
        rst = 1'b1;
        #1;
        check("async_count", 32'(if_m.bit_count), 32'd0);
        check("async_word",  32'(if_m.word_out),  32'h00);
        if_m.bit_in    = 1'b1;
        if_m.bit_valid = 1'b1;
        tick();
        rst            = 1'b0;
        if_m.bit_valid = 1'b0;
        check("rst_edge_nosample", 32'(if_m.bit_count), 32'd0);
        send_frame(8'hA5, 1'b0, 0, FRAME - 1);
        check("a5_count", 32'(if_m.bit_count), 32'(FRAME - 1));
        send_frame(8'hA5, 1'b0, FRAME - 1, FRAME);
        check("a5_word",   32'(if_m.word_out),   32'hA5);
        check("a5_valid",  32'(if_m.word_valid), 32'h1);
        check("a5_count0", 32'(if_m.bit_count),  32'd0);
        tick();

`ifdef DESER_PARITY_EN
        // Parity: 8'h03 has even ones, so the correct parity bit is 0
        send_frame(8'h03, 1'b1, 0, FRAME);
        check("par_bad_word", 32'(if_m.word_out),   32'h03);
        check("par_bad_err",  32'(if_m.parity_err), 32'h1);
        tick();
        send_frame(8'h03, 1'b0, 0, FRAME);
        check("par_ok_err",   32'(if_m.parity_err), 32'h0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bit_deserializer.md
BIT_DESERIALIZER -- requirements
Module: bit_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per word (legal range 2..16).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, where 1 means the first received bit is word bit WIDTH-1 and 0 means it is bit 0.
REQ-003 The block SHALL have port clk, input, 1 bit, the single rising-edge clock for all state.
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port bit_in, input, 1 bit, the serial data bit.
REQ-006 The block SHALL have port bit_valid, input, 1 bit; bit_in is sampled only on edges where bit_valid=1.
REQ-007 The block SHALL have port word_out, output, WIDTH bits, the assembled parallel word.
REQ-008 The block SHALL have port word_valid, output, 1 bit, meaning word_out holds an unconsumed word.
REQ-009 The block SHALL have port word_ready, input, 1 bit; word_valid=1 and word_ready=1 on an edge consumes the word.
REQ-010 The block SHALL have port overflow, output, 1 bit, a sticky flag meaning a completed word was dropped.
REQ-011 The block SHALL have port clr_ovf, input, 1 bit, which clears overflow synchronously.
REQ-012 The block SHALL have port bit_count, output, clog2(WIDTH+1) bits, the number of bits collected toward the current word.

Function
REQ-013 On each edge with bit_valid=1, the block SHALL shift bit_in into an internal shift register and increment bit_count.
REQ-014 The shift direction SHALL follow MSB_FIRST (see REQ-002).
REQ-015 The block SHALL have two states: COLLECT, active while bit_count < WIDTH-1 bits are held, and COMPLETE, which covers the edge that samples bit WIDTH.
REQ-016 On the COMPLETE edge, bit_count SHALL wrap to 0, and the full word SHALL be offered to the output register in the same edge.
REQ-017 Latency SHALL be one cycle: word_valid=1 and word_out are visible in the cycle after the edge that sampled the last bit.
REQ-018 If word_valid=0 at a COMPLETE edge, the new word SHALL load into the output register and word_valid SHALL be set.
REQ-019 If word_valid=1 and word_ready=1 at a COMPLETE edge, the old word SHALL be consumed, the new word SHALL load, and word_valid SHALL remain 1 with no bubble.
REQ-020 If word_valid=1 and word_ready=0 at a COMPLETE edge, the new word SHALL be dropped, word_out SHALL be retained, and overflow SHALL be set.
REQ-021 A consume edge without a COMPLETE edge SHALL clear word_valid; word_out SHALL hold its last value.
REQ-022 word_out SHALL remain stable while word_valid=1 and word_ready=0.
REQ-023 bit_valid=0 SHALL freeze the shift register and bit_count for any number of cycles, with no timeout.
REQ-024 If clr_ovf=1 and an overflow event occur on the same edge, overflow SHALL end at 1 (set wins).
REQ-025 word_ready SHALL be ignored while word_valid=0.

Reset
REQ-026 While rst=1, the block SHALL force word_out=0, word_valid=0, overflow=0, bit_count=0 and shift register=0, immediately and without a clock.
REQ-027 A reset asserted mid-word SHALL discard any partial word; after release, the next valid bit SHALL be counted as bit 1.
REQ-028 Reset deassertion SHALL take effect at the next rising clk edge; no bit SHALL be sampled on an edge where rst=1.

Configuration
REQ-029 Macro DESER_PARITY_EN, when defined, SHALL add output parity_err (1 bit) and extend each frame to WIDTH+1 bits, the last bit being even parity over the data bits.
REQ-030 With DESER_PARITY_EN defined, parity_err SHALL load together with the word: 1 if the parity bit mismatches, otherwise 0.
REQ-031 With DESER_PARITY_EN defined, parity_err SHALL reset to 0 and SHALL be dropped along with the word under REQ-020.
REQ-032 Without DESER_PARITY_EN, frames SHALL be exactly WIDTH bits and port parity_err SHALL NOT exist.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_out=8'hB2 with word_valid=1 for exactly one cycle, starting the cycle after bit 8.
REQ-034 MSB_FIRST=0, same bit sequence -> word_out=8'h4D.
REQ-035 Word 8'hB2 held with word_ready=0, then 8 bits of 8'hFF sent -> word_out stays 8'hB2 and overflow=1; after clr_ovf pulse -> overflow=0.
REQ-036 Back-to-back words 8'h12 then 8'h34 with word_ready=1 continuously -> word_valid stays high with no bubble across the second COMPLETE edge, and each word is seen once.
REQ-037 rst pulsed after 5 bits of a word, then 8 bits of 8'hA5 sent -> word_out=8'hA5 and bit_count=0 after completion.
REQ-038 With DESER_PARITY_EN, data 8'h03 with parity bit 1 -> parity_err=1; with parity bit 0 -> parity_err=0.
